// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage with a 2-entry skid buffer between fetch and execute.
// Define DECODE_MEXT_EN to decode the M extension; otherwise M encodings are illegal.
module decode_stage #(
    parameter int XLEN   = 64,
    parameter int PRIV_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [PRIV_W-1:0] priv_lvl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_alu_op,
    output logic [15:0]       out_ctrl,
    output logic [XLEN/8-1:0] out_mem_be,
    output logic [11:0]       out_csr_addr,
    output logic              out_exc_en,
    output logic [3:0]        out_exc_code,
    output logic [XLEN-1:0]   out_exc_val
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_NOP  = 5'd10;
    localparam logic [4:0] ALU_SLT  = 5'd11;
    localparam logic [4:0] ALU_SLTU = 5'd12;
    localparam logic [4:0] ALU_SLL  = 5'd13;
    localparam logic [4:0] ALU_SRL  = 5'd14;
    localparam logic [4:0] ALU_SRA  = 5'd15;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   imm;
        logic [4:0]        alu_op;
        logic [15:0]       ctrl;
        logic [XLEN/8-1:0] mem_be;
        logic [11:0]       csr_addr;
        logic              exc_en;
        logic [3:0]        exc_code;
        logic [XLEN-1:0]   exc_val;
    } bundle_t;

    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign rd_f   = in_instr[11:7];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    bundle_t     dec;
    logic [4:0]  ra1, ra2, rad, alu;
    logic [31:0] imm32;
    logic [7:0]  be;
    logic [11:0] csr;
    logic        illegal, exc;
    logic [3:0]  code;
    logic        c_we_regs, c_we_dmem, c_load, c_store, c_branch, c_jal, c_jalr;
    logic        c_csr, c_32, c_auipc, c_bimm, c_mret;

    // Decode the incoming word; anything flagged illegal collapses to a clean exception bundle.
    always_comb begin
        ra1 = '0; ra2 = '0; rad = '0; alu = ALU_ADD; imm32 = '0; be = '0; csr = '0;
        illegal = 1'b0; exc = 1'b0; code = '0;
        c_we_regs = 1'b0; c_we_dmem = 1'b0; c_load = 1'b0; c_store = 1'b0;
        c_branch = 1'b0; c_jal = 1'b0; c_jalr = 1'b0; c_csr = 1'b0;
        c_32 = 1'b0; c_auipc = 1'b0; c_bimm = 1'b0; c_mret = 1'b0;
        dec = '0;

        case (opcode)
            7'b0110111: begin
                rad = rd_f; imm32 = imm_u; c_we_regs = 1'b1; c_bimm = 1'b1;
            end
            7'b0010111: begin
                rad = rd_f; imm32 = imm_u; c_we_regs = 1'b1; c_bimm = 1'b1; c_auipc = 1'b1;
            end
            7'b1101111: begin
                rad = rd_f; imm32 = imm_j; c_we_regs = 1'b1; c_jal = 1'b1;
            end
            7'b1100111: begin
                ra1 = rs1_f; rad = rd_f; imm32 = imm_i;
                c_we_regs = 1'b1; c_jalr = 1'b1; c_bimm = 1'b1;
                illegal = (f3 != 3'b000);
            end
            7'b1100011: begin
                ra1 = rs1_f; ra2 = rs2_f; imm32 = imm_b; c_branch = 1'b1;
                case (f3)
                    3'b000, 3'b001: alu = ALU_SUB;
                    3'b100, 3'b101: alu = ALU_SLT;
                    3'b110, 3'b111: alu = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                ra1 = rs1_f; rad = rd_f; imm32 = imm_i;
                c_we_regs = 1'b1; c_load = 1'b1; c_bimm = 1'b1;
                case (f3)
                    3'b000, 3'b100: be = 8'h01;
                    3'b001, 3'b101: be = 8'h03;
                    3'b010:         be = 8'h0F;
                    3'b110:         begin be = 8'h0F; illegal = !RV64; end
                    3'b011:         begin be = 8'hFF; illegal = !RV64; end
                    default:        illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                ra1 = rs1_f; ra2 = rs2_f; imm32 = imm_s;
                c_we_dmem = 1'b1; c_store = 1'b1; c_bimm = 1'b1;
                case (f3)
                    3'b000:  be = 8'h01;
                    3'b001:  be = 8'h03;
                    3'b010:  be = 8'h0F;
                    3'b011:  begin be = 8'hFF; illegal = !RV64; end
                    default: illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                ra1 = rs1_f; rad = rd_f; imm32 = imm_i; c_we_regs = 1'b1; c_bimm = 1'b1;
                alu = alu_from_f3(f3, 1'b0);
                if (f3[1:0] == 2'b01) begin
                    imm32 = {26'b0, in_instr[25:20]};
                    alu   = alu_from_f3(f3, in_instr[30]);
                    if (in_instr[31] || (in_instr[29:26] != 4'b0) ||
                        (in_instr[30] && !f3[2]) || (!RV64 && in_instr[25]))
                        illegal = 1'b1;
                end
            end
            7'b0011011: begin
                ra1 = rs1_f; rad = rd_f; imm32 = imm_i;
                c_we_regs = 1'b1; c_bimm = 1'b1; c_32 = 1'b1;
                illegal = !RV64;
                case (f3)
                    3'b000: alu = ALU_ADD;
                    3'b001, 3'b101: begin
                        imm32 = {27'b0, in_instr[24:20]};
                        alu   = alu_from_f3(f3, in_instr[30]);
                        if (in_instr[31] || (in_instr[29:25] != 5'b0) || (in_instr[30] && !f3[2]))
                            illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            7'b0110011: begin
                ra1 = rs1_f; ra2 = rs2_f; rad = rd_f; c_we_regs = 1'b1;
                case (f7)
                    7'b0000000: alu = alu_from_f3(f3, 1'b0);
                    7'b0100000: begin
                        alu = alu_from_f3(f3, 1'b1);
                        illegal = !((f3 == 3'b000) || (f3 == 3'b101));
                    end
`ifdef DECODE_MEXT_EN
                    7'b0000001: alu = {2'b10, f3};
`endif
                    default: illegal = 1'b1;
                endcase
            end
            7'b0111011: begin
                ra1 = rs1_f; ra2 = rs2_f; rad = rd_f; c_we_regs = 1'b1; c_32 = 1'b1;
                case (f7)
                    7'b0000000: begin
                        alu = alu_from_f3(f3, 1'b0);
                        illegal = !RV64 || !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101));
                    end
                    7'b0100000: begin
                        alu = alu_from_f3(f3, 1'b1);
                        illegal = !RV64 || !((f3 == 3'b000) || (f3 == 3'b101));
                    end
`ifdef DECODE_MEXT_EN
                    7'b0000001: begin
                        alu = {2'b10, f3};
                        illegal = !RV64 || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            7'b0001111: alu = ALU_NOP;
            7'b1110011: begin
                alu = ALU_NOP;
                if (f3 == 3'b000) begin
                    case (in_instr)
                        32'h0000_0073: begin
                            exc = 1'b1;
                            case (priv_lvl)
                                PRIV_W'(0): code = 4'd8;
                                PRIV_W'(1): code = 4'd9;
                                default:    code = 4'd11;
                            endcase
                        end
                        32'h0010_0073: begin exc = 1'b1; code = 4'd3; end
                        32'h3020_0073: c_mret = 1'b1;
                        default:       illegal = 1'b1;
                    endcase
                end else if (f3 == 3'b100) begin
                    illegal = 1'b1;
                end else begin
                    c_csr = 1'b1; csr = in_instr[31:20]; rad = rd_f;
                    c_we_regs = (rd_f != 5'd0);
                    if (f3[2]) imm32 = {27'b0, rs1_f};
                    else       ra1 = rs1_f;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (in_instr[1:0] != 2'b11)
            illegal = 1'b1;

        dec.pc       = in_pc;
        dec.rs1      = ra1;
        dec.rs2      = ra2;
        dec.rd       = rad;
        dec.imm      = sext32(imm32);
        dec.alu_op   = alu;
        dec.ctrl     = {c_we_regs, c_we_dmem, c_load, c_store, c_branch, c_jal, c_jalr,
                        c_csr, c_32, c_auipc, c_bimm, c_mret, f3, 1'b0};
        dec.mem_be   = be[XLEN/8-1:0];
        dec.csr_addr = csr;
        dec.exc_en   = exc;
        dec.exc_code = code;
        dec.exc_val  = '0;

        if (illegal) begin
            dec.rs1      = '0;
            dec.rs2      = '0;
            dec.rd       = '0;
            dec.imm      = '0;
            dec.alu_op   = ALU_NOP;
            dec.ctrl     = '0;
            dec.mem_be   = '0;
            dec.csr_addr = '0;
            dec.exc_en   = 1'b1;
            dec.exc_code = 4'd2;
            dec.exc_val  = XLEN'(in_instr);
        end
    end

    state_t  state, state_n;
    bundle_t out_q, skid_q;
    logic    accept, drain, load_out, load_skid, from_skid;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Occupancy control; flush clears only the valid state, payload registers are left alone.
    always_comb begin
        state_n   = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin load_out = 1'b1; state_n = ONE; end
                ONE: begin
                    if (accept && drain)  load_out = 1'b1;
                    else if (accept)      begin load_skid = 1'b1; state_n = TWO; end
                    else if (drain)       state_n = EMPTY;
                end
                TWO: if (drain) begin load_out = 1'b1; from_skid = 1'b1; state_n = ONE; end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_n;
            if (load_out)  out_q  <= from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign out_pc       = out_q.pc;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_rd       = out_q.rd;
    assign out_imm      = out_q.imm;
    assign out_alu_op   = out_q.alu_op;
    assign out_ctrl     = out_q.ctrl;
    assign out_mem_be   = out_q.mem_be;
    assign out_csr_addr = out_q.csr_addr;
    assign out_exc_en   = out_q.exc_en;
    assign out_exc_code = out_q.exc_code;
    assign out_exc_val  = out_q.exc_val;

endmodule
